alu_exec: RTL and testbench
===========================

# alu_exec

Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder; performs the selected operation on two 32-bit operands and returns a registered result with a start/busy/done handshake. Single-cycle ops complete in one clock; MUL and DIV run on a shared iterative radix-2 datapath. Sits in the EX stage between the register-file read ports and the writeback/HI-LO logic.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only when busy=0
- alu_op  in  4  control code: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NOR, 0111 SLL, 1000 SRL, 1001 SLT, 1010 XOR; 1011-1111 execute as ADD
- a  in  32  operand rs
- b  in  32  operand rt
- shamt  in  5  shift amount for SLL/SRL
- result  out  32  registered result; MUL low word, DIV quotient
- hi  out  32  registered MUL high word or DIV remainder; 0 for other ops
- zero  out  1  combinational, result==0
- ovf  out  1  registered signed overflow for ADD/SUB; 0 otherwise
- div_by_zero  out  1  registered; 1 only for a DIV with b==0
- busy  out  1  high while an iterative op is in progress
- done  out  1  one-cycle pulse when result/hi/flags update

## Operation
- FSM states: IDLE, ITER, SIGN.
- IDLE, start=1, single-cycle op: result, hi, ovf, div_by_zero written at that edge; done=1 next cycle; stay IDLE.
- ADD/SUB: 32-bit wrap; ovf = operands' signs compatible and result sign differs.
- AND/OR/NOR/XOR bitwise; SLL result=b<<shamt; SRL result=b>>shamt (logical); SLT result={31'b0, signed a<signed b}.
- IDLE, start=1, MUL: latch |a|, |b|, result sign; go ITER, counter=31.
- IDLE, start=1, DIV, b!=0: latch |a|, |b|, quotient sign (a^b), remainder sign (a); go ITER, counter=31.
- IDLE, start=1, DIV, b==0: single-cycle; result=32'hFFFF_FFFF, hi=a, div_by_zero=1.
- ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge; counter decrements; at counter==0 go SIGN.
- SIGN: negate 64-bit product or quotient/remainder per latched signs; write result/hi; done=1 next cycle; go IDLE.
- DIV semantics: quotient truncates toward zero, remainder takes dividend sign. 0x8000_0000 / -1 -> result 0x8000_0000, hi 0, no flag.
- MUL: signed 32x32->64, {hi,result}.
- start while busy=1 ignored; alu_op/a/b/shamt need not be held after the accepting edge.
- result/hi/flags hold until the next completion.

## Timing
- Reset values: result 0, hi 0, ovf 0, div_by_zero 0, busy 0, done 0, zero 1; FSM IDLE.
- Single-cycle ops (incl. DIV by zero): done high in the cycle after the accepting edge (latency 1).
- MUL/DIV: busy high 33 cycles (32 ITER + 1 SIGN) starting the cycle after acceptance; done high in the cycle after the SIGN edge, same cycle busy falls (latency 33).
- New start may be accepted in the cycle done is high (busy=0); back-to-back single-cycle ops give done every cycle.
- rst_n low at any edge, including mid-ITER/SIGN: abort, all outputs to reset values at that edge, no done for the aborted op.

## Configuration
- ALU_EXEC_MULDIV_EN defined: iterative MUL/DIV as above.
- Undefined: ITER/SIGN and iterative datapath omitted; MUL and DIV complete single-cycle with result 0, hi 0, div_by_zero 0; busy tied 0.

## Test plan
- Reset then start ADD a=0x7FFF_FFFF b=1 -> next cycle done=1, result 0x8000_0000, ovf=1, zero=0; SUB a=5 b=5 -> result 0, zero=1.
- SLT a=0xFFFF_FFFF b=1 -> result 1; SRL b=0x8000_0000 shamt=31 -> result 1; SLL b=1 shamt=4 -> 0x10; alu_op 1111 a=2 b=3 -> 5.
- MUL a=-3 b=7 -> busy 33 cycles, done at latency 33, {hi,result}=0xFFFF_FFFF_FFFF_FFEB; start pulsed mid-op ignored.
- DIV a=-7 b=2 -> result 0xFFFF_FFFD, hi 0xFFFF_FFFF; DIV 0x8000_0000 by -1 -> result 0x8000_0000, hi 0; DIV a=9 b=0 -> latency 1, result 0xFFFF_FFFF, hi 9, div_by_zero=1.
- MUL started, rst_n low at cycle 10 -> outputs reset, no done; next ADD 1+1 completes with result 2.
- Build without ALU_EXEC_MULDIV_EN: MUL 3*4 -> latency 1, result 0, hi 0, busy never high.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: EX-stage ALU consuming the 4-bit ALU control code.
// Single-cycle ops register their result at the accepting edge. MUL and DIV
// share one iterative radix-2 datapath (shift-add / restoring shift-subtract)
// on operand magnitudes, with signs applied in a final SIGN cycle.
// Build option: define ALU_EXEC_MULDIV_EN to include the iterative MUL/DIV
// datapath; when undefined, MUL and DIV complete in one cycle with zeroed
// result/hi/div_by_zero and busy is tied low.
// Handshake: start is sampled only at an edge where busy=0; the op is
// accepted at that edge and operands need not be held afterwards. done is a
// one-cycle pulse in the cycle result/hi/ovf/div_by_zero take new values;
// those outputs then hold until the next completion.
module alu_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic        zero,
  output logic        ovf,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  logic [31:0] add_sum;
  logic [31:0] sub_diff;
  logic        add_ovf;
  logic        sub_ovf;

  // Single-cycle outcome of the presented op, written at the accepting edge.
  logic [31:0] sc_result;
  logic [31:0] sc_hi;
  logic        sc_ovf;
  logic        sc_dbz;

  assign add_sum  = a + b;
  assign sub_diff = a - b;
  // Signed overflow: like-signed operands (ADD) or unlike-signed (SUB)
  // producing a result whose sign differs from a.
  assign add_ovf  = (a[31] == b[31]) && (add_sum[31] != a[31]);
  assign sub_ovf  = (a[31] != b[31]) && (sub_diff[31] != a[31]);

  // zero tracks the registered result combinationally.
  assign zero = (result == 32'd0);

  // Decode the control code into the single-cycle result and flags.
  always_comb begin
    sc_result = add_sum;
    sc_hi     = 32'd0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    case (alu_op)
      OP_SUB: begin
        sc_result = sub_diff;
        sc_ovf    = sub_ovf;
      end
      OP_MUL: sc_result = 32'd0;
      OP_DIV: begin
        sc_result = 32'd0;
`ifdef ALU_EXEC_MULDIV_EN
        // Divide by zero never enters the iterative path.
        if (b == 32'd0) begin
          sc_result = 32'hFFFF_FFFF;
          sc_hi     = a;
          sc_dbz    = 1'b1;
        end
`endif
      end
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_NOR: sc_result = ~(a | b);
      OP_SLL: sc_result = b << shamt;
      OP_SRL: sc_result = b >> shamt;
      OP_SLT: sc_result = {31'd0, ($signed(a) < $signed(b))};
      OP_XOR: sc_result = a ^ b;
      // OP_ADD and the unused codes 1011-1111 all execute as ADD.
      default: begin
        sc_result = add_sum;
        sc_ovf    = add_ovf;
      end
    endcase
  end

`ifdef ALU_EXEC_MULDIV_EN

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Shared iterative datapath. MUL: acc_hi:acc_lo is the partial product with
  // the multiplier shifting out of acc_lo. DIV: acc_hi is the remainder and
  // acc_lo the dividend shifting out while quotient bits shift in.
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opnd;
  logic [4:0]  cnt;
  logic        op_div;
  logic        neg_lo;
  logic        neg_hi;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        accept_iter;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_sub;
  logic        div_ok;
  logic [63:0] prod_neg;

  // Magnitudes; 0x8000_0000 maps to itself, which is its correct unsigned value.
  assign abs_a = a[31] ? (32'd0 - a) : a;
  assign abs_b = b[31] ? (32'd0 - b) : b;

  assign accept_iter = (state == IDLE) && start &&
                       ((alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b != 32'd0)));

  // MUL step: conditionally add the multiplicand into the upper half.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
  // DIV step: shift the next dividend bit into the remainder and trial-subtract.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  // When div_ok holds the true difference is below opnd, so 32 bits suffice.
  assign div_sub   = div_shift[31:0] - opnd;
  assign prod_neg  = 64'd0 - {acc_hi, acc_lo};

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> ITER on an iterative accept, 32 ITER steps, one SIGN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_iter) state_nxt = ITER;
      ITER:    if (cnt == 5'd0) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers: accept, iterate, then sign-correct and commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result      <= 32'd0;
      hi          <= 32'd0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      acc_hi      <= 32'd0;
      acc_lo      <= 32'd0;
      opnd        <= 32'd0;
      cnt         <= 5'd0;
      op_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_iter) begin
            op_div <= (alu_op == OP_DIV);
            acc_hi <= 32'd0;
            cnt    <= 5'd31;
            neg_lo <= a[31] ^ b[31];
            if (alu_op == OP_DIV) begin
              acc_lo <= abs_a;
              opnd   <= abs_b;
              neg_hi <= a[31];
            end else begin
              acc_lo <= abs_b;
              opnd   <= abs_a;
              neg_hi <= a[31] ^ b[31];
            end
          end else if (start) begin
            result      <= sc_result;
            hi          <= sc_hi;
            ovf         <= sc_ovf;
            div_by_zero <= sc_dbz;
            done        <= 1'b1;
          end
        end
        ITER: begin
          if (op_div) begin
            acc_hi <= div_ok ? div_sub : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ok};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
          cnt <= cnt - 5'd1;
        end
        SIGN: begin
          if (op_div) begin
            result <= neg_lo ? (32'd0 - acc_lo) : acc_lo;
            hi     <= neg_hi ? (32'd0 - acc_hi) : acc_hi;
          end else begin
            {hi, result} <= neg_lo ? prod_neg : {acc_hi, acc_lo};
          end
          ovf         <= 1'b0;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`else

  assign busy = 1'b0;

  // Every op, MUL and DIV included, commits at the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result      <= 32'd0;
      hi          <= 32'd0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        result      <= sc_result;
        hi          <= sc_hi;
        ovf         <= sc_ovf;
        div_by_zero <= sc_dbz;
        done        <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against an
// arithmetic reference model (signed 64-bit integer math on the operands).
// Works with and without ALU_EXEC_MULDIV_EN defined.
module tb_alu_exec;

`ifdef ALU_EXEC_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  // Expected entry: {div_by_zero, ovf, hi, result}
  localparam int EXP_W = 66;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        ovf;
  logic        div_by_zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];

  alu_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .ovf         (ovf),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op.
  function automatic logic [EXP_W-1:0] model(input logic [3:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [4:0] sh);
    longint sx, sy, s, q, rm;
    logic [31:0] r, h;
    logic o, d;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 32'd0; h = 32'd0; o = 1'b0; d = 1'b0;
    case (op)
      4'd1: begin
        s = sx - sy;
        r = 32'(s);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: if (MULDIV_EN) begin
        s = sx * sy;
        r = 32'(s);
        h = 32'(s >>> 32);
      end
      4'd3: if (MULDIV_EN) begin
        if (y == 32'd0) begin
          r = 32'hFFFF_FFFF; h = x; d = 1'b1;
        end else begin
          q  = sx / sy;
          rm = sx % sy;
          r = 32'(q);
          h = 32'(rm);
        end
      end
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = ~(x | y);
      4'd7:  r = y << sh;
      4'd8:  r = y >> sh;
      4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: r = x ^ y;
      default: begin
        s = sx + sy;
        r = 32'(s);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    return {d, o, h, r};
  endfunction

  function automatic bit is_iter(input logic [3:0] op, input logic [31:0] y);
    return MULDIV_EN && ((op == 4'd2) || ((op == 4'd3) && (y != 32'd0)));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_hi"}, hi, 32'd0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_dbz"}, div_by_zero, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_zero"}, zero, 1'b1);
  endtask

  // Issue one op, wait for done, compare against the scoreboard entry.
  // poke pulses start mid-operation; it must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] sh, input bit poke);
    logic [EXP_W-1:0] e;
    logic [31:0] er, eh;
    logic eo, ed;
    int busy_cnt, n;
    bit iter_exp;
    exp_q.push_back(model(op, x, y, sh));
    iter_exp = is_iter(op, y);
    @(negedge clk);
    start = 1'b1; alu_op = op; a = x; b = y; shamt = sh;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom); shamt = 5'($urandom);
    busy_cnt = 0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) busy_cnt++;
      start = poke && (n == 5);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_cycles"}, busy_cnt, iter_exp ? 33 : 0);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    e = exp_q.pop_front();
    {ed, eo, eh, er} = e;
    check({tag, "_result"}, result, er);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_dbz"}, div_by_zero, ed);
    check({tag, "_zero"}, zero, (er == 32'd0));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_result_hold"}, result, er);
  endtask

  // Back-to-back single-cycle ops with start held high: done every cycle.
  task automatic run_burst(input int cnt);
    logic [EXP_W-1:0] e;
    logic [3:0] op;
    logic [31:0] x, y;
    logic [4:0] sh;
    for (int i = 0; i < cnt; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd2) op = op + 4'd2;
      x = pick_operand();
      y = pick_operand();
      sh = 5'($urandom);
      exp_q.push_back(model(op, x, y, sh));
      @(negedge clk);
      start = 1'b1; alu_op = op; a = x; b = y; shamt = sh;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("burst_done", done, 1'b1);
      check("burst_result", result, e[31:0]);
      check("burst_hi", hi, e[63:32]);
      check("burst_ovf", ovf, e[64]);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Directed sequence followed by randomized ops.
  initial begin
    int seen;
    logic [3:0] rop;
    do_reset();
    #1;
    check_reset_outputs("reset");

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 5'd0, 1'b0);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
    run_op("slt_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("srl_31", 4'd8, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
    run_op("sll_4", 4'd7, 32'd0, 32'd1, 5'd4, 1'b0);
    run_op("op_1111", 4'd15, 32'd2, 32'd3, 5'd0, 1'b0);
    run_op("nor", 4'd6, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0);
    run_op("mul_neg", 4'd2, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
    run_op("div_min", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op("div_zero", 4'd3, 32'd9, 32'd0, 5'd0, 1'b0);
    run_op("mul_small", 4'd2, 32'd3, 32'd4, 5'd0, 1'b0);

    // Reset during an iterative op: no done afterwards, then a clean ADD.
    @(negedge clk);
    start = 1'b1; alu_op = 4'd2; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    check("midop_no_done", seen, 0);
    run_op("add_after_reset", 4'd0, 32'd1, 32'd1, 5'd0, 1'b0);

    run_burst(8);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (i % 4 == 0) rop = 4'd2 + 4'($urandom_range(0, 1));
      run_op("rand", rop, pick_operand(), pick_operand(), 5'($urandom), i[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
